cgp_output_monitor: RTL and testbench
=====================================

CGP_OUTPUT_MONITOR -- requirements
Module: cgp_output_monitor

Interface
REQ-001 Parameter WINDOW, default 32: number of captured samples of the observed bit; even, 4..64.
REQ-002 Parameter SKIP, default 2: settle cycles discarded after start before capture; 0..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin one measurement; honoured only in IDLE.
REQ-006 in_bit  input  1  observed serial bit (the out_0 of the evolved circuit under test).
REQ-007 result_ready  input  1  consumer accepts the result.
REQ-008 busy  output  1  high in SETTLE, CAPTURE and ANALYZE.
REQ-009 result_valid  output  1  result fields valid; high only in DONE.
REQ-010 capture  output  WINDOW  captured samples; sample k is at bit k.
REQ-011 ones_count  output  $clog2(WINDOW+1)  number of 1 samples.
REQ-012 toggle_count  output  $clog2(WINDOW+1)  number of sample-to-sample changes.
REQ-013 period  output  $clog2(WINDOW+1)  smallest repeat period, 0 if none.
REQ-014 period_found  output  1  period is valid and nonzero.

Function
REQ-015 FSM states: IDLE, SETTLE, CAPTURE, ANALYZE, DONE.
REQ-016 IDLE with start=1: go to SETTLE, load skip counter with SKIP, clear all result registers; go straight to CAPTURE when SKIP=0.
REQ-017 SETTLE: in_bit ignored; after SKIP cycles go to CAPTURE.
REQ-018 CAPTURE: on each cycle store in_bit at capture[k], with k=0..WINDOW-1 in order.
REQ-019 CAPTURE: ones_count increments on each 1 sample.
REQ-020 CAPTURE: toggle_count increments when sample k differs from sample k-1; sample 0 is never counted.
REQ-021 CAPTURE: after WINDOW samples go to ANALYZE with candidate p=1.
REQ-022 ANALYZE tests one candidate per cycle; p matches iff capture[i]==capture[i+p] for all i<WINDOW-p.
REQ-023 ANALYZE on a match: period=p, period_found=1, go to DONE.
REQ-024 ANALYZE with no match at p=WINDOW/2: period=0, period_found=0, go to DONE.
REQ-025 Latency: result_valid rises SKIP+WINDOW+P edges after the edge that samples start; P is the matched p, or WINDOW/2 if there is no match.
REQ-026 DONE: result_valid=1 and all result outputs held stable until result_valid and result_ready are both high on the same edge.
REQ-027 On that handshake edge, go to IDLE; result_valid is low from the next cycle; result fields keep their values until the next start.
REQ-028 start is ignored in every state except IDLE, including DONE.
REQ-029 result_ready is ignored outside DONE.
REQ-030 Counters saturate at WINDOW; no wrap-around is reachable.

Reset
REQ-031 reset low forces IDLE asynchronously in any state, including mid-CAPTURE and mid-ANALYZE; the partial measurement is discarded.
REQ-032 Reset values: busy=0, result_valid=0, and capture, ones_count, toggle_count, period, period_found all 0.
REQ-033 After reset release, the first start yields a complete, fresh measurement.

Structure
REQ-034 Shared package cgp_mon_pkg holds the FSM state enum and the default WINDOW/SKIP constants.
REQ-035 One sub-module, cgp_period_match: combinational, takes capture and p, returns match.

Verification (WINDOW=32, SKIP=2)
REQ-036 in_bit constant 1 -> capture=0xFFFFFFFF, ones=32, toggles=0, period=1, found=1, result_valid 35 edges after start.
REQ-037 in_bit alternating starting at 0 -> capture=0xAAAAAAAA, ones=16, toggles=31, period=2, found=1.
REQ-038 Repeating pattern 1,1,0 -> ones=22, toggles=20, period=3, found=1.
REQ-039 Single 1 at sample 0, rest 0 -> ones=1, toggles=1, period=0, found=0, result_valid 50 edges after start.
REQ-040 result_ready held 0 for 10 cycles in DONE, with start pulsed -> outputs unchanged, start ignored; ready=1 -> IDLE next cycle.
REQ-041 reset low at capture sample 10 -> all outputs 0, busy=0; next start gives a correct full result.

Source files
------------

// File: rtl/cgp_mon_pkg.sv
// Shared types and defaults for the evolved-circuit output monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cgp_mon_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_ANALYZE,
    ST_DONE
  } mon_state_t;

  localparam int DEFAULT_WINDOW = 32;
  localparam int DEFAULT_SKIP   = 2;

endpackage

// File: rtl/cgp_period_match.sv
// Tests whether a captured window repeats with a candidate period p.
// Latency: combinational.
// Backpressure: none; pure function of capture and p.
module cgp_period_match
  import cgp_mon_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic [WINDOW-1:0]            capture,
  input  logic [$clog2(WINDOW+1)-1:0]  p,
  output logic                         match
);

  logic [WINDOW-1:0] valid_mask;
  logic [WINDOW-1:0] diff;

  // Shifting by p lines sample i+p up with sample i; only the low WINDOW-p lanes have a partner
  always_comb begin
    valid_mask = {WINDOW{1'b1}} >> p;
    diff       = (capture ^ (capture >> p)) & valid_mask;
    match      = ~|diff;
  end

endmodule

// File: rtl/cgp_output_monitor.sv
// Captures WINDOW samples of a serial bit after SKIP settle cycles, then reports ones, toggles and period.
// Latency: result_valid rises SKIP+WINDOW+P edges after start (P = matched period or WINDOW/2).
// Backpressure: result held in DONE until result_valid && result_ready; start ignored until back in IDLE.
module cgp_output_monitor
  import cgp_mon_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,  // even, 4..64
  parameter int SKIP   = DEFAULT_SKIP     // 0..255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_bit,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         result_valid,
  output logic [WINDOW-1:0]            capture,
  output logic [$clog2(WINDOW+1)-1:0]  ones_count,
  output logic [$clog2(WINDOW+1)-1:0]  toggle_count,
  output logic [$clog2(WINDOW+1)-1:0]  period,
  output logic                         period_found
);

  localparam int CW = $clog2(WINDOW+1);
  localparam int KW = $clog2(WINDOW);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WINDOW);
  localparam logic [CW-1:0] P_LAST   = CW'(WINDOW/2);
  localparam logic [KW-1:0] K_LAST   = KW'(WINDOW-1);

  mon_state_t    state_q, state_d;
  logic [7:0]    skip_cnt;
  logic [KW-1:0] k_q;
  logic [CW-1:0] p_q;
  logic          prev_bit;
  logic          match;

  cgp_period_match #(.WINDOW(WINDOW)) u_match (
    .capture (capture),
    .p       (p_q),
    .match   (match)
  );

  // State register; reset abandons any measurement in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (SKIP == 0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (skip_cnt == 8'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (k_q == K_LAST) state_d = ST_ANALYZE;
      end
      ST_ANALYZE: begin
        busy = 1'b1;
        if (match || (p_q == P_LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Measurement datapath: settle countdown, sample capture with running stats, period search
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_cnt     <= '0;
      k_q          <= '0;
      p_q          <= '0;
      prev_bit     <= 1'b0;
      capture      <= '0;
      ones_count   <= '0;
      toggle_count <= '0;
      period       <= '0;
      period_found <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            skip_cnt     <= 8'(SKIP);
            k_q          <= '0;
            p_q          <= CW'(1);
            prev_bit     <= 1'b0;
            capture      <= '0;
            ones_count   <= '0;
            toggle_count <= '0;
            period       <= '0;
            period_found <= 1'b0;
          end
        end
        ST_SETTLE: begin
          skip_cnt <= skip_cnt - 8'd1;
        end
        ST_CAPTURE: begin
          capture[k_q] <= in_bit;
          prev_bit     <= in_bit;
          k_q          <= k_q + KW'(1);
          if (in_bit && (ones_count < CNT_MAX))
            ones_count <= ones_count + CW'(1);
          // Sample 0 has no predecessor, so it never counts as a toggle
          if ((k_q != '0) && (in_bit != prev_bit) && (toggle_count < CNT_MAX))
            toggle_count <= toggle_count + CW'(1);
        end
        ST_ANALYZE: begin
          if (match) begin
            period       <= p_q;
            period_found <= 1'b1;
          end else if (p_q != P_LAST) begin
            p_q <= p_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgp_output_monitor.sv
module tb_cgp_output_monitor;

  localparam int W    = 32;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_bit = 1'b0;
  logic        result_ready = 1'b0;
  logic        busy, result_valid, period_found;
  logic [W-1:0] capture;
  logic [5:0]  ones_count, toggle_count, period;

  int n_checks = 0;
  int n_fail   = 0;

  cgp_output_monitor #(.WINDOW(W), .SKIP(SKIP)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .in_bit       (in_bit),
    .result_ready (result_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .capture      (capture),
    .ones_count   (ones_count),
    .toggle_count (toggle_count),
    .period       (period),
    .period_found (period_found)
  );

  always #5 clk = ~clk;

  // Reference model: statistics straight from the definition of each field
  task automatic model(input logic [W-1:0] pat, output int ones, output int tog,
                       output int per, output int lat);
    ones = 0; tog = 0; per = 0;
    for (int k = 0; k < W; k++) begin
      if (pat[k]) ones++;
      if (k > 0 && pat[k] != pat[k-1]) tog++;
    end
    for (int p = 1; p <= W/2; p++) begin
      bit ok = 1'b1;
      for (int i = 0; i < W - p; i++) if (pat[i] != pat[i+p]) ok = 1'b0;
      if (ok && per == 0) per = p;
    end
    lat = SKIP + W + ((per != 0) ? per : W/2);
  endtask

  // Drives one measurement; returns edges from start to result_valid (-1 on timeout)
  task automatic run_measure(input logic [W-1:0] pat, output int lat, output logic busy1);
    lat = -1;
    busy1 = 1'b0;
    @(negedge clk); start = 1'b1; in_bit = 1'($urandom);
    @(posedge clk); #1; start = 1'b0;
    busy1 = busy;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n > SKIP && n <= SKIP + W) in_bit = pat[n-SKIP-1];
      else                           in_bit = 1'($urandom);
      @(posedge clk); #1;
      if (result_valid) begin lat = n; break; end
    end
    if (lat < 0) begin
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
    end
  endtask

  task automatic handshake();
    @(negedge clk); result_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 7;
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid); end
    if (capture !== '0)        begin n_fail++; $display("FAIL reset_capture got %h want 0", capture); end
    if (ones_count !== '0)     begin n_fail++; $display("FAIL reset_ones got %0d want 0", ones_count); end
    if (toggle_count !== '0)   begin n_fail++; $display("FAIL reset_toggles got %0d want 0", toggle_count); end
    if (period !== '0)         begin n_fail++; $display("FAIL reset_period got %0d want 0", period); end
    if (period_found !== 1'b0) begin n_fail++; $display("FAIL reset_found got %b want 0", period_found); end
    @(negedge clk); start = 1'b0; result_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant_one();
    int lat; logic b1;
    run_measure({W{1'b1}}, lat, b1);
    n_checks += 7;
    if (b1 !== 1'b1)            begin n_fail++; $display("FAIL const1_busy got %b want 1", b1); end
    if (lat !== 35)             begin n_fail++; $display("FAIL const1_latency got %0d want 35", lat); end
    if (capture !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL const1_capture got %h want ffffffff", capture); end
    if (ones_count !== 6'd32)   begin n_fail++; $display("FAIL const1_ones got %0d want 32", ones_count); end
    if (toggle_count !== 6'd0)  begin n_fail++; $display("FAIL const1_toggles got %0d want 0", toggle_count); end
    if (period !== 6'd1)        begin n_fail++; $display("FAIL const1_period got %0d want 1", period); end
    if (period_found !== 1'b1)  begin n_fail++; $display("FAIL const1_found got %b want 1", period_found); end
    handshake();
  endtask

  task automatic test_alternating();
    int lat; logic b1;
    run_measure(32'hAAAAAAAA, lat, b1);
    n_checks += 6;
    if (lat !== 36)             begin n_fail++; $display("FAIL alt_latency got %0d want 36", lat); end
    if (capture !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL alt_capture got %h want aaaaaaaa", capture); end
    if (ones_count !== 6'd16)   begin n_fail++; $display("FAIL alt_ones got %0d want 16", ones_count); end
    if (toggle_count !== 6'd31) begin n_fail++; $display("FAIL alt_toggles got %0d want 31", toggle_count); end
    if (period !== 6'd2)        begin n_fail++; $display("FAIL alt_period got %0d want 2", period); end
    if (period_found !== 1'b1)  begin n_fail++; $display("FAIL alt_found got %b want 1", period_found); end
    handshake();
  endtask

  task automatic test_single_one();
    int lat; logic b1;
    run_measure(32'h00000001, lat, b1);
    n_checks += 6;
    if (lat !== 50)             begin n_fail++; $display("FAIL single_latency got %0d want 50", lat); end
    if (capture !== 32'h1)      begin n_fail++; $display("FAIL single_capture got %h want 1", capture); end
    if (ones_count !== 6'd1)    begin n_fail++; $display("FAIL single_ones got %0d want 1", ones_count); end
    if (toggle_count !== 6'd1)  begin n_fail++; $display("FAIL single_toggles got %0d want 1", toggle_count); end
    if (period !== 6'd0)        begin n_fail++; $display("FAIL single_period got %0d want 0", period); end
    if (period_found !== 1'b0)  begin n_fail++; $display("FAIL single_found got %b want 0", period_found); end
    handshake();
  endtask

  // 1,1,0 repeating, then hold the result under backpressure with a stray start
  task automatic test_backpressure();
    logic [W-1:0] pat;
    int lat; logic b1;
    for (int k = 0; k < W; k++) pat[k] = (k % 3 != 2);
    run_measure(pat, lat, b1);
    n_checks += 6;
    if (lat !== 37)             begin n_fail++; $display("FAIL p110_latency got %0d want 37", lat); end
    if (capture !== pat)        begin n_fail++; $display("FAIL p110_capture got %h want %h", capture, pat); end
    if (ones_count !== 6'd22)   begin n_fail++; $display("FAIL p110_ones got %0d want 22", ones_count); end
    if (toggle_count !== 6'd20) begin n_fail++; $display("FAIL p110_toggles got %0d want 20", toggle_count); end
    if (period !== 6'd3)        begin n_fail++; $display("FAIL p110_period got %0d want 3", period); end
    if (period_found !== 1'b1)  begin n_fail++; $display("FAIL p110_found got %b want 1", period_found); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); start = (c == 3 || c == 4); in_bit = 1'($urandom);
      @(posedge clk); #1;
      n_checks += 4;
      if (result_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cycle %0d got %b want 1", c, result_valid); end
      if (capture !== pat)       begin n_fail++; $display("FAIL hold_capture cycle %0d got %h want %h", c, capture, pat); end
      if (period !== 6'd3)       begin n_fail++; $display("FAIL hold_period cycle %0d got %0d want 3", c, period); end
      if (busy !== 1'b0)         begin n_fail++; $display("FAIL hold_busy cycle %0d got %b want 0", c, busy); end
    end
    @(negedge clk); start = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); result_ready = 1'b0;
    n_checks += 4;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got %b want 0", result_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL release_busy got %b want 0", busy); end
    if (capture !== pat)       begin n_fail++; $display("FAIL release_capture got %h want %h", capture, pat); end
    if (ones_count !== 6'd22)  begin n_fail++; $display("FAIL release_ones got %0d want 22", ones_count); end
  endtask

  task automatic test_reset_mid_capture();
    logic [W-1:0] pat;
    int lat, ones, tog, per, mlat; logic b1;
    @(negedge clk); start = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 1; n <= SKIP + 10; n++) begin
      @(negedge clk); in_bit = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", result_valid); end
    if (capture !== '0)        begin n_fail++; $display("FAIL midrst_capture got %h want 0", capture); end
    if (ones_count !== '0)     begin n_fail++; $display("FAIL midrst_ones got %0d want 0", ones_count); end
    if (toggle_count !== '0)   begin n_fail++; $display("FAIL midrst_toggles got %0d want 0", toggle_count); end
    if (period !== '0 || period_found !== 1'b0) begin n_fail++; $display("FAIL midrst_period got %0d/%b want 0/0", period, period_found); end
    @(negedge clk); rst_n = 1'b1;
    pat = 32'h0F0F0F0F;
    model(pat, ones, tog, per, mlat);
    run_measure(pat, lat, b1);
    n_checks += 5;
    if (lat !== mlat)            begin n_fail++; $display("FAIL postrst_latency got %0d want %0d", lat, mlat); end
    if (capture !== pat)         begin n_fail++; $display("FAIL postrst_capture got %h want %h", capture, pat); end
    if (ones_count !== 6'(ones)) begin n_fail++; $display("FAIL postrst_ones got %0d want %0d", ones_count, ones); end
    if (toggle_count !== 6'(tog)) begin n_fail++; $display("FAIL postrst_toggles got %0d want %0d", toggle_count, tog); end
    if (period !== 6'(per) || period_found !== (per != 0)) begin n_fail++; $display("FAIL postrst_period got %0d/%b want %0d", period, period_found, per); end
    handshake();
  endtask

  task automatic test_random();
    logic [W-1:0] pat, base;
    int lat, ones, tog, per, mlat, p; logic b1;
    for (int t = 0; t < 12; t++) begin
      base = $urandom;
      if (t % 2 == 0) begin
        p = $urandom_range(1, W/2);
        for (int k = 0; k < W; k++) pat[k] = base[k % p];
      end else begin
        pat = base;
      end
      model(pat, ones, tog, per, mlat);
      run_measure(pat, lat, b1);
      n_checks += 5;
      if (lat !== mlat)            begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", t, lat, mlat); end
      if (capture !== pat)         begin n_fail++; $display("FAIL rand%0d_capture got %h want %h", t, capture, pat); end
      if (ones_count !== 6'(ones)) begin n_fail++; $display("FAIL rand%0d_ones got %0d want %0d", t, ones_count, ones); end
      if (toggle_count !== 6'(tog)) begin n_fail++; $display("FAIL rand%0d_toggles got %0d want %0d", t, toggle_count, tog); end
      if (period !== 6'(per) || period_found !== (per != 0)) begin n_fail++; $display("FAIL rand%0d_period got %0d/%b want %0d", t, period, period_found, per); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_constant_one();
    test_alternating();
    test_single_one();
    test_backpressure();
    test_reset_mid_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
